// File: rtl/baccarat_datapath.sv
// Baccarat round datapath: captures dealt cards on control strobes, scores both hands,
// settles the wager against the round result and flags out-of-order strobes.
module baccarat_datapath #(
  parameter int START_BALANCE = 100,
  parameter int WAGER_AMT     = 10,
  parameter int TIE_MULT      = 8
) (
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic [3:0] new_card,
  input  logic       load_wager,
  input  logic [1:0] bet_in,
  input  logic       load_pcard1,
  input  logic       load_pcard2,
  input  logic       load_pcard3,
  input  logic       load_dcard1,
  input  logic       load_dcard2,
  input  logic       load_dcard3,
  input  logic [1:0] result,
  output logic [3:0] pcard1,
  output logic [3:0] pcard2,
  output logic [3:0] pcard3,
  output logic [3:0] dcard1,
  output logic [3:0] dcard2,
  output logic [3:0] dcard3,
  output logic [3:0] pscore,
  output logic [3:0] dscore,
  output logic [3:0] pcard3_val,
  output logic [1:0] bet_q,
  output logic [7:0] balance,
  output logic       settled,
  output logic       seq_err,
  output logic       broke
);

  localparam logic signed [9:0] WIN_AMT   = 10'(WAGER_AMT);
  localparam logic signed [9:0] TIE_AMT   = 10'(TIE_MULT * WAGER_AMT);
  localparam logic [7:0]        RESET_BAL = 8'(START_BALANCE);

  typedef enum logic [3:0] {IDLE, WAGERED, P1, D1, P2, D2, P3, D3, DONE} phase_t;

  phase_t phase, phase_nxt, phase_adv;

  logic [5:0]        strobes;
  logic [5:0]        cap;
  logic [3:0]        card_in;
  logic              card_ok;
  logic              legal;
  logic              settle_ok;
  logic              do_settle;
  logic              set_err;
  logic signed [9:0] bal_sum;

  function automatic logic [3:0] card_val(input logic [3:0] code);
    return (code >= 4'd1 && code <= 4'd9) ? code : 4'd0;
  endfunction

  // Max raw sum is 27, so one conditional subtraction of 10 or 20 gives mod 10.
  function automatic logic [3:0] hand_score(input logic [3:0] c1, input logic [3:0] c2,
                                            input logic [3:0] c3);
    logic [4:0] sum;
    sum = {1'b0, card_val(c1)} + {1'b0, card_val(c2)} + {1'b0, card_val(c3)};
    if (sum >= 5'd20)      sum = sum - 5'd20;
    else if (sum >= 5'd10) sum = sum - 5'd10;
    return sum[3:0];
  endfunction

  function automatic logic signed [9:0] payout(input logic [1:0] bet, input logic [1:0] res);
    logic signed [9:0] delta;
    delta = 10'sd0;
    case (bet)
      2'b01:   if (res == 2'b01) delta = WIN_AMT; else if (res == 2'b10) delta = -WIN_AMT;
      2'b10:   if (res == 2'b10) delta = WIN_AMT; else if (res == 2'b01) delta = -WIN_AMT;
      2'b11:   delta = (res == 2'b11) ? TIE_AMT : -WIN_AMT;
      default: delta = 10'sd0;
    endcase
    return delta;
  endfunction

  function automatic logic [7:0] sat_balance(input logic signed [9:0] x);
    if (x < 10'sd0)   return 8'd0;
    if (x > 10'sd255) return 8'd255;
    return x[7:0];
  endfunction

  assign strobes    = {load_pcard1, load_dcard1, load_pcard2, load_dcard2, load_pcard3, load_dcard3};
  assign card_ok    = (new_card >= 4'd1) && (new_card <= 4'd13);
  assign card_in    = card_ok ? new_card : 4'd0;
  assign settle_ok  = (result != 2'b00) && !settled && (phase == D2 || phase == P3 || phase == D3);
  assign bal_sum    = $signed({2'b00, balance}) + payout(bet_q, result);
  assign pscore     = hand_score(pcard1, pcard2, pcard3);
  assign dscore     = hand_score(dcard1, dcard2, dcard3);
  assign pcard3_val = card_val(pcard3);
  assign broke      = balance < 8'(WAGER_AMT);

  // Exact one-hot match against the expected strobe also rejects simultaneous strobes.
  always_comb begin
    legal     = 1'b0;
    phase_adv = phase;
    case (phase)
      WAGERED: if (strobes == 6'b100000) begin legal = 1'b1; phase_adv = P1; end
      P1:      if (strobes == 6'b010000) begin legal = 1'b1; phase_adv = D1; end
      D1:      if (strobes == 6'b001000) begin legal = 1'b1; phase_adv = P2; end
      P2:      if (strobes == 6'b000100) begin legal = 1'b1; phase_adv = D2; end
      D2: begin
        if (strobes == 6'b000010)      begin legal = 1'b1; phase_adv = P3; end
        else if (strobes == 6'b000001) begin legal = 1'b1; phase_adv = D3; end
      end
      P3:      if (strobes == 6'b000001) begin legal = 1'b1; phase_adv = D3; end
      default: ;
    endcase
  end

  always_comb begin
    phase_nxt = phase;
    cap       = 6'b000000;
    set_err   = 1'b0;
    do_settle = 1'b0;
    if (load_wager) begin
      phase_nxt = WAGERED;
    end else if (settle_ok) begin
      do_settle = 1'b1;
      phase_nxt = DONE;
    end else begin
      if (|strobes) begin
        if (legal) begin
          phase_nxt = phase_adv;
          cap       = strobes;
          set_err   = !card_ok;
        end else begin
          set_err   = 1'b1;
        end
      end
      if (result != 2'b00 && (phase == P1 || phase == D1 || phase == P2)) set_err = 1'b1;
    end
  end

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) phase <= IDLE;
    else         phase <= phase_nxt;
  end

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      pcard1  <= 4'd0;
      pcard2  <= 4'd0;
      pcard3  <= 4'd0;
      dcard1  <= 4'd0;
      dcard2  <= 4'd0;
      dcard3  <= 4'd0;
      bet_q   <= 2'b00;
      balance <= RESET_BAL;
      settled <= 1'b0;
      seq_err <= 1'b0;
    end else if (load_wager) begin
      pcard1  <= 4'd0;
      pcard2  <= 4'd0;
      pcard3  <= 4'd0;
      dcard1  <= 4'd0;
      dcard2  <= 4'd0;
      dcard3  <= 4'd0;
      bet_q   <= broke ? 2'b00 : bet_in;
      settled <= 1'b0;
      seq_err <= 1'b0;
    end else begin
      if (cap[5]) pcard1 <= card_in;
      if (cap[4]) dcard1 <= card_in;
      if (cap[3]) pcard2 <= card_in;
      if (cap[2]) dcard2 <= card_in;
      if (cap[1]) pcard3 <= card_in;
      if (cap[0]) dcard3 <= card_in;
      if (do_settle) begin
        balance <= sat_balance(bal_sum);
        settled <= 1'b1;
      end
      if (set_err) seq_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_baccarat_datapath.sv
// Bench for baccarat_datapath: directed scenarios plus randomized traffic against a
// round-level reference model (deal order list, balance as an integer).
module tb_baccarat_datapath;

  logic       slow_clock = 1'b0;
  logic       resetb = 1'b1;
  logic [3:0] new_card = 4'd0;
  logic       load_wager = 1'b0;
  logic [1:0] bet_in = 2'b00;
  logic       load_pcard1 = 1'b0, load_pcard2 = 1'b0, load_pcard3 = 1'b0;
  logic       load_dcard1 = 1'b0, load_dcard2 = 1'b0, load_dcard3 = 1'b0;
  logic [1:0] result = 2'b00;
  logic [3:0] pcard1, pcard2, pcard3, dcard1, dcard2, dcard3;
  logic [3:0] pscore, dscore, pcard3_val;
  logic [1:0] bet_q;
  logic [7:0] balance;
  logic       settled, seq_err, broke;

  int tests_run = 0;
  int failed = 0;

  baccarat_datapath #(.START_BALANCE(100), .WAGER_AMT(10), .TIE_MULT(8)) dut (
    .slow_clock(slow_clock), .resetb(resetb), .new_card(new_card),
    .load_wager(load_wager), .bet_in(bet_in),
    .load_pcard1(load_pcard1), .load_pcard2(load_pcard2), .load_pcard3(load_pcard3),
    .load_dcard1(load_dcard1), .load_dcard2(load_dcard2), .load_dcard3(load_dcard3),
    .result(result),
    .pcard1(pcard1), .pcard2(pcard2), .pcard3(pcard3),
    .dcard1(dcard1), .dcard2(dcard2), .dcard3(dcard3),
    .pscore(pscore), .dscore(dscore), .pcard3_val(pcard3_val),
    .bet_q(bet_q), .balance(balance), .settled(settled), .seq_err(seq_err), .broke(broke)
  );

  always #5 slow_clock = ~slow_clock;

  // Reference model: slots 0..5 are the deal order P1 D1 P2 D2 P3 D3.
  int         m_bal;
  logic [3:0] m_card [6];
  logic [1:0] m_bet;
  bit         m_settled, m_err, m_active;
  int         m_deal [$];

  task automatic model_reset();
    m_bal = 100;
    for (int k = 0; k < 6; k++) m_card[k] = 4'd0;
    m_bet = 2'b00;
    m_settled = 0;
    m_err = 0;
    m_active = 0;
    m_deal.delete();
  endtask

  function automatic bit m_legal(int slot);
    int n;
    n = m_deal.size();
    if (!m_active || m_settled) return 0;
    if (n < 4) return slot == n;
    if (n == 4) return slot == 4 || slot == 5;
    if (n == 5 && m_deal[4] == 4) return slot == 5;
    return 0;
  endfunction

  function automatic int m_val(logic [3:0] c);
    return (c >= 1 && c <= 9) ? int'(c) : 0;
  endfunction

  task automatic model_step(input bit w, input logic [1:0] b, input logic [5:0] sv,
                            input logic [3:0] c, input logic [1:0] r);
    int n0, d, slot;
    n0 = m_deal.size();
    if (w) begin
      for (int k = 0; k < 6; k++) m_card[k] = 4'd0;
      m_deal.delete();
      m_settled = 0;
      m_err = 0;
      m_active = 1;
      m_bet = (m_bal < 10) ? 2'b00 : b;
    end else if (r != 0 && m_active && !m_settled && n0 >= 4) begin
      if (m_bet == 0)      d = 0;
      else if (m_bet == 3) d = (r == 3) ? 80 : -10;
      else if (r == m_bet) d = 10;
      else if (r == 3)     d = 0;
      else                 d = -10;
      m_bal = m_bal + d;
      if (m_bal < 0) m_bal = 0;
      if (m_bal > 255) m_bal = 255;
      m_settled = 1;
    end else begin
      if ($countones(sv) == 1) begin
        slot = 0;
        for (int k = 0; k < 6; k++) if (sv[k]) slot = k;
        if (m_legal(slot)) begin
          if (c >= 1 && c <= 13) m_card[slot] = c;
          else begin m_card[slot] = 4'd0; m_err = 1; end
          m_deal.push_back(slot);
        end else m_err = 1;
      end else if ($countones(sv) > 1) m_err = 1;
      if (r != 0 && m_active && !m_settled && n0 >= 1 && n0 <= 3) m_err = 1;
    end
  endtask

  function automatic logic [48:0] exp_vec();
    return {m_card[0], m_card[2], m_card[4], m_card[1], m_card[3], m_card[5],
            4'((m_val(m_card[0]) + m_val(m_card[2]) + m_val(m_card[4])) % 10),
            4'((m_val(m_card[1]) + m_val(m_card[3]) + m_val(m_card[5])) % 10),
            4'(m_val(m_card[4])), m_bet, 8'(m_bal), m_settled, m_err, (m_bal < 10)};
  endfunction

  wire [48:0] dut_vec = {pcard1, pcard2, pcard3, dcard1, dcard2, dcard3, pscore, dscore,
                         pcard3_val, bet_q, balance, settled, seq_err, broke};

  task automatic cycle(input bit w, input logic [1:0] b, input logic [5:0] sv,
                       input logic [3:0] c, input logic [1:0] r);
    load_wager = w; bet_in = b; new_card = c; result = r;
    load_pcard1 = sv[0]; load_dcard1 = sv[1]; load_pcard2 = sv[2];
    load_dcard2 = sv[3]; load_pcard3 = sv[4]; load_dcard3 = sv[5];
    model_step(w, b, sv, c, r);
    @(posedge slow_clock);
    #1;
    load_wager = 0; bet_in = 2'b00; new_card = 4'd0; result = 2'b00;
    {load_dcard3, load_pcard3, load_dcard2, load_pcard2, load_dcard1, load_pcard1} = 6'b0;
  endtask

  task automatic strobe(input int slot, input logic [3:0] c);
    cycle(0, 2'b00, 6'(1 << slot), c, 2'b00);
  endtask

  task automatic deal4(input logic [3:0] c1, input logic [3:0] c2, input logic [3:0] c3,
                       input logic [3:0] c4);
    strobe(0, c1); strobe(1, c2); strobe(2, c3); strobe(3, c4);
  endtask

  task automatic test_reset();
    #1 resetb = 0;
    model_reset();
    #2;
    tests_run++;
    if ({pcard1, pcard2, pcard3, dcard1, dcard2, dcard3} !== 24'd0) begin
      failed++; $display("FAIL reset_cards got %h want 0", {pcard1, pcard2, pcard3, dcard1, dcard2, dcard3});
    end
    tests_run++;
    if ({balance, bet_q, settled, seq_err, broke} !== {8'd100, 2'b00, 3'b000}) begin
      failed++; $display("FAIL reset_ctrl got bal=%0d bet=%b st=%b err=%b broke=%b want 100 00 0 0 0",
                         balance, bet_q, settled, seq_err, broke);
    end
    @(negedge slow_clock) resetb = 1;
  endtask

  task automatic test_round1();
    cycle(1, 2'b01, 6'b0, 4'd0, 2'b00);
    deal4(4'd7, 4'd3, 4'd2, 4'd5);
    tests_run++;
    if ({pscore, dscore, seq_err} !== {4'd9, 4'd8, 1'b0}) begin
      failed++; $display("FAIL round1_scores got p=%0d d=%0d err=%b want 9 8 0", pscore, dscore, seq_err);
    end
    cycle(0, 2'b00, 6'b0, 4'd0, 2'b01);
    tests_run++;
    if ({balance, settled} !== {8'd110, 1'b1}) begin
      failed++; $display("FAIL round1_settle got bal=%0d st=%b want 110 1", balance, settled);
    end
    for (int i = 0; i < 3; i++) cycle(0, 2'b00, 6'b0, 4'd0, 2'b01);
    tests_run++;
    if (balance !== 8'd110) begin
      failed++; $display("FAIL round1_hold got %0d want 110", balance);
    end
  endtask

  task automatic test_face_third();
    cycle(1, 2'b01, 6'b0, 4'd0, 2'b00);
    deal4(4'd12, 4'd13, 4'd5, 4'd1);
    strobe(4, 4'd9);
    tests_run++;
    if ({pscore, pcard3_val, dscore} !== {4'd4, 4'd9, 4'd1}) begin
      failed++; $display("FAIL face_p3 got p=%0d p3v=%0d d=%0d want 4 9 1", pscore, pcard3_val, dscore);
    end
    strobe(5, 4'd6);
    tests_run++;
    if (dscore !== 4'd7) begin
      failed++; $display("FAIL face_d3 got %0d want 7", dscore);
    end
    cycle(0, 2'b00, 6'b0, 4'd0, 2'b10);
    tests_run++;
    if (balance !== 8'd100) begin
      failed++; $display("FAIL face_loss got %0d want 100", balance);
    end
  endtask

  task automatic test_tie();
    logic [1:0] res [4] = '{2'b11, 2'b10, 2'b11, 2'b11};
    logic [7:0] want [4] = '{8'd180, 8'd170, 8'd250, 8'd255};
    for (int i = 0; i < 4; i++) begin
      cycle(1, 2'b11, 6'b0, 4'd0, 2'b00);
      deal4(4'd1, 4'd2, 4'd3, 4'd4);
      cycle(0, 2'b00, 6'b0, 4'd0, res[i]);
      tests_run++;
      if (balance !== want[i]) begin
        failed++; $display("FAIL tie_round%0d got %0d want %0d", i, balance, want[i]);
      end
    end
  endtask

  task automatic test_protocol();
    cycle(1, 2'b01, 6'b0, 4'd0, 2'b00);
    strobe(1, 4'd5);
    tests_run++;
    if ({dcard1, seq_err} !== {4'd0, 1'b1}) begin
      failed++; $display("FAIL proto_d1_in_wagered got d1=%0d err=%b want 0 1", dcard1, seq_err);
    end
    cycle(1, 2'b01, 6'b0, 4'd0, 2'b00);
    strobe(0, 4'd14);
    tests_run++;
    if ({pcard1, seq_err} !== {4'd0, 1'b1}) begin
      failed++; $display("FAIL proto_bad_code got p1=%0d err=%b want 0 1", pcard1, seq_err);
    end
    cycle(1, 2'b01, 6'b0, 4'd0, 2'b00);
    strobe(0, 4'd7);
    strobe(1, 4'd3);
    cycle(0, 2'b00, 6'b001100, 4'd6, 2'b00);
    tests_run++;
    if ({pcard2, dcard2, seq_err} !== {4'd0, 4'd0, 1'b1}) begin
      failed++; $display("FAIL proto_double got p2=%0d d2=%0d err=%b want 0 0 1", pcard2, dcard2, seq_err);
    end
    cycle(1, 2'b01, 6'b0, 4'd0, 2'b00);
    tests_run++;
    if (seq_err !== 1'b0) begin
      failed++; $display("FAIL proto_clear got %b want 0", seq_err);
    end
  endtask

  task automatic test_broke();
    for (int i = 0; i < 25; i++) begin
      cycle(1, 2'b01, 6'b0, 4'd0, 2'b00);
      deal4(4'd1, 4'd1, 4'd1, 4'd1);
      cycle(0, 2'b00, 6'b0, 4'd0, 2'b10);
    end
    tests_run++;
    if ({balance, broke} !== {8'd5, 1'b1}) begin
      failed++; $display("FAIL broke_flag got bal=%0d broke=%b want 5 1", balance, broke);
    end
    cycle(1, 2'b01, 6'b0, 4'd0, 2'b00);
    tests_run++;
    if (bet_q !== 2'b00) begin
      failed++; $display("FAIL broke_bet got %b want 00", bet_q);
    end
    deal4(4'd2, 4'd2, 4'd2, 4'd2);
    cycle(0, 2'b00, 6'b0, 4'd0, 2'b10);
    tests_run++;
    if ({balance, settled} !== {8'd5, 1'b1}) begin
      failed++; $display("FAIL broke_settle got bal=%0d st=%b want 5 1", balance, settled);
    end
  endtask

  task automatic test_reset_mid();
    cycle(1, 2'b00, 6'b0, 4'd0, 2'b00);
    strobe(0, 4'd3); strobe(1, 4'd4); strobe(2, 4'd5);
    #2 resetb = 0;
    model_reset();
    #1;
    tests_run++;
    if ({pcard1, dcard1, pcard2, balance} !== {12'd0, 8'd100}) begin
      failed++; $display("FAIL reset_mid got p1=%0d d1=%0d p2=%0d bal=%0d want 0 0 0 100",
                         pcard1, dcard1, pcard2, balance);
    end
    @(negedge slow_clock) resetb = 1;
  endtask

  task automatic test_priority();
    strobe(0, 4'd4);
    tests_run++;
    if ({pcard1, seq_err} !== {4'd0, 1'b1}) begin
      failed++; $display("FAIL idle_strobe got p1=%0d err=%b want 0 1", pcard1, seq_err);
    end
    cycle(1, 2'b01, 6'b0, 4'd0, 2'b00);
    deal4(4'd1, 4'd2, 4'd3, 4'd4);
    cycle(1, 2'b01, 6'b0, 4'd0, 2'b01);
    tests_run++;
    if ({balance, settled, pcard1} !== {8'd100, 1'b0, 4'd0}) begin
      failed++; $display("FAIL prio_wager got bal=%0d st=%b p1=%0d want 100 0 0", balance, settled, pcard1);
    end
    strobe(0, 4'd4);
    tests_run++;
    if ({pcard1, seq_err} !== {4'd4, 1'b0}) begin
      failed++; $display("FAIL prio_wagered got p1=%0d err=%b want 4 0", pcard1, seq_err);
    end
  endtask

  task automatic test_random();
    bit         w;
    logic [1:0] b, r;
    logic [5:0] sv;
    logic [3:0] c;
    int         p, bad;
    int         legal_q [$];
    bad = 0;
    for (int i = 0; i < 800; i++) begin
      w = ($urandom_range(0, 11) == 0);
      b = 2'($urandom_range(0, 3));
      p = $urandom_range(0, 99);
      legal_q.delete();
      for (int k = 0; k < 6; k++) if (m_legal(k)) legal_q.push_back(k);
      if (p < 45 && legal_q.size() > 0) sv = 6'(1 << legal_q[$urandom_range(0, legal_q.size() - 1)]);
      else if (p < 65) sv = 6'(1 << $urandom_range(0, 5));
      else if (p < 70) sv = 6'($urandom_range(0, 63));
      else sv = 6'b0;
      c = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 13));
      r = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      cycle(w, b, sv, c, r);
      tests_run++;
      if (dut_vec !== exp_vec()) begin
        failed++;
        if (bad < 10) $display("FAIL random_cycle%0d got %h want %h", i, dut_vec, exp_vec());
        bad++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_round1();
    test_face_third();
    test_tie();
    test_protocol();
    test_broke();
    test_reset_mid();
    test_priority();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
